// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronise/debounce pll_lock, request PLL reset on timeout, count events.
// Optional PLL_LOCK_GLITCH_LOG_EN adds glitch_cnt and last_glitch_len outputs.
module pll_lock_supervisor #(
   parameter int SYNC_STAGES   = 3,
   parameter int STABLE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int RST_PULSE     = 16,
   parameter int CNT_W         = 8
) (
   input  logic             clk_tb,
   input  logic             rst_n,
   input  logic             pll_lock,
   input  logic             clr_err,
   output logic             lock_stable,
   output logic             pll_rst_req,
   output logic             err_sticky,
   output logic [CNT_W-1:0] relock_cnt,
   output logic [CNT_W-1:0] timeout_cnt,
`ifdef PLL_LOCK_GLITCH_LOG_EN
   output logic [CNT_W-1:0] glitch_cnt,
   output logic [15:0]      last_glitch_len,
`endif
   output logic [2:0]       state
);

   localparam int MAX_A = (STABLE_CYCLES > LOCK_TIMEOUT) ? STABLE_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_T = (MAX_A > RST_PULSE) ? MAX_A : RST_PULSE;
   localparam int TMR_W = $clog2(MAX_T);

   localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(RST_PULSE - 1);

   localparam logic [2:0] S_WAIT_LOCK = 3'd0;
   localparam logic [2:0] S_DEBOUNCE  = 3'd1;
   localparam logic [2:0] S_LOCKED    = 3'd2;
   localparam logic [2:0] S_LOST      = 3'd3;
   localparam logic [2:0] S_RST_REQ   = 3'd4;

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
         $error("pll_lock_supervisor: SYNC_STAGES must be 2..4");
      end
      if (STABLE_CYCLES < 2 || LOCK_TIMEOUT < 2 || RST_PULSE < 2) begin : g_bad_tmr
         $error("pll_lock_supervisor: STABLE_CYCLES, LOCK_TIMEOUT, RST_PULSE must be >= 2");
      end
   endgenerate

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
      return (inc && (c != '1)) ? c + 1'b1 : c;
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lk_s;
   logic [TMR_W-1:0]       tmr, tmr_nxt;
   logic [2:0]             state_nxt;
   logic                   relock_inc, timeout_inc, err_set;

   always_ff @(posedge clk_tb or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
   end
   assign lk_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_nxt   = state;
      tmr_nxt     = tmr;
      relock_inc  = 1'b0;
      timeout_inc = 1'b0;
      err_set     = 1'b0;
      case (state)
         S_WAIT_LOCK: begin
            if (lk_s) begin
               state_nxt = S_DEBOUNCE;
               tmr_nxt   = '0;
            end else if (tmr == TIMEOUT_LAST) begin
               state_nxt   = S_RST_REQ;
               tmr_nxt     = '0;
               timeout_inc = 1'b1;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         S_DEBOUNCE: begin
            // a drop during debounce is a glitch, not a relock
            if (!lk_s) begin
               state_nxt = S_WAIT_LOCK;
               tmr_nxt   = '0;
            end else if (tmr == STABLE_LAST) begin
               state_nxt  = S_LOCKED;
               tmr_nxt    = '0;
               relock_inc = 1'b1;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         S_LOCKED: begin
            if (!lk_s) begin
               state_nxt = S_LOST;
               err_set   = 1'b1;
            end
         end
         S_LOST: begin
            state_nxt = S_WAIT_LOCK;
            tmr_nxt   = '0;
         end
         S_RST_REQ: begin
            // lk_s deliberately ignored until the pulse completes
            if (tmr == PULSE_LAST) begin
               state_nxt = S_WAIT_LOCK;
               tmr_nxt   = '0;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         default: begin
            state_nxt = S_WAIT_LOCK;
            tmr_nxt   = '0;
         end
      endcase
   end

   // Moore outputs registered off the next state so they move with state
   always_ff @(posedge clk_tb or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_WAIT_LOCK;
         tmr         <= '0;
         lock_stable <= 1'b0;
         pll_rst_req <= 1'b0;
      end else begin
         state       <= state_nxt;
         tmr         <= tmr_nxt;
         lock_stable <= (state_nxt == S_LOCKED);
         pll_rst_req <= (state_nxt == S_RST_REQ);
      end
   end

   always_ff @(posedge clk_tb or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky  <= 1'b0;
         relock_cnt  <= '0;
         timeout_cnt <= '0;
      end else if (clr_err) begin
         err_sticky  <= 1'b0;
         relock_cnt  <= '0;
         timeout_cnt <= '0;
      end else begin
         err_sticky  <= err_sticky | err_set;
         relock_cnt  <= sat_inc(relock_cnt, relock_inc);
         timeout_cnt <= sat_inc(timeout_cnt, timeout_inc);
      end
   end

`ifdef PLL_LOCK_GLITCH_LOG_EN
   logic glitch;
   assign glitch = (state == S_DEBOUNCE) && !lk_s;

   always_ff @(posedge clk_tb or negedge rst_n) begin
      if (!rst_n) begin
         glitch_cnt      <= '0;
         last_glitch_len <= '0;
      end else begin
         glitch_cnt <= clr_err ? '0 : sat_inc(glitch_cnt, glitch);
         if (glitch) last_glitch_len <= 16'(tmr);
      end
   end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: vector table + scoreboard queue, then hand-written corner sequences.
module tb_pll_lock_supervisor;
   localparam int CW = 8;

   logic          clk_tb = 1'b0;
   logic          rst_n = 1'b0;
   logic          pll_lock = 1'b0;
   logic          clr_err = 1'b0;
   logic          lock_stable, pll_rst_req, err_sticky;
   logic [CW-1:0] relock_cnt, timeout_cnt;
   logic [2:0]    state;
`ifdef PLL_LOCK_GLITCH_LOG_EN
   logic [CW-1:0] glitch_cnt;
   logic [15:0]   last_glitch_len;
`endif

   always #5 clk_tb = ~clk_tb;

   pll_lock_supervisor #(
      .SYNC_STAGES(3), .STABLE_CYCLES(16), .LOCK_TIMEOUT(100), .RST_PULSE(4), .CNT_W(CW)
   ) dut (
      .clk_tb(clk_tb), .rst_n(rst_n), .pll_lock(pll_lock), .clr_err(clr_err),
      .lock_stable(lock_stable), .pll_rst_req(pll_rst_req), .err_sticky(err_sticky),
      .relock_cnt(relock_cnt), .timeout_cnt(timeout_cnt),
`ifdef PLL_LOCK_GLITCH_LOG_EN
      .glitch_cnt(glitch_cnt), .last_glitch_len(last_glitch_len),
`endif
      .state(state)
   );

   typedef struct {
      logic          lock, clr;
      int            n;
      logic          ls, rq, err;
      logic [CW-1:0] rl, to;
      logic [2:0]    st;
      logic [CW-1:0] gc;
      logic [15:0]   gl;
   } vec_t;

   int   n_run = 0;
   int   n_fail = 0;
   vec_t tbl[22];
   vec_t sbq[$];

   function automatic vec_t mk(input logic lock, input logic clr, input int n,
                               input logic ls, input logic rq, input logic err,
                               input int rl, input int to, input int st, input int gc, input int gl);
      vec_t v;
      v.lock = lock; v.clr = clr; v.n = n;
      v.ls = ls; v.rq = rq; v.err = err;
      v.rl = CW'(rl); v.to = CW'(to); v.st = 3'(st); v.gc = CW'(gc); v.gl = 16'(gl);
      return v;
   endfunction

   function automatic logic [63:0] pack_exp(input vec_t e);
      logic [CW-1:0] gc;
      logic [15:0]   gl;
`ifdef PLL_LOCK_GLITCH_LOG_EN
      gc = e.gc; gl = e.gl;
`else
      gc = '0; gl = '0;
`endif
      return 64'({e.ls, e.rq, e.err, e.rl, e.to, e.st, gc, gl});
   endfunction

   function automatic logic [63:0] snap();
      logic [CW-1:0] gc;
      logic [15:0]   gl;
`ifdef PLL_LOCK_GLITCH_LOG_EN
      gc = glitch_cnt; gl = last_glitch_len;
`else
      gc = '0; gl = '0;
`endif
      return 64'({lock_stable, pll_rst_req, err_sticky, relock_cnt, timeout_cnt, state, gc, gl});
   endfunction

   task automatic step(input int k);
      repeat (k) @(posedge clk_tb);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      vec_t e;
      // cycle k = just after clock edge k counted from reset release
      //             lock clr  n   ls rq er rl to st gc gl
      tbl[0]  = mk(0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0);  // 10: idle
      tbl[1]  = mk(1, 0, 19, 0, 0, 0, 0, 0, 1, 0, 0);  // 29: still debouncing
      tbl[2]  = mk(1, 0, 1,  1, 0, 0, 1, 0, 2, 0, 0);  // 30: clean lock
      tbl[3]  = mk(0, 0, 3,  1, 0, 0, 1, 0, 2, 0, 0);  // 33: drop not yet seen
      tbl[4]  = mk(0, 0, 1,  0, 0, 1, 1, 0, 3, 0, 0);  // 34: LOST, 4 cycles after drop
      tbl[5]  = mk(0, 0, 1,  0, 0, 1, 1, 0, 0, 0, 0);  // 35: back to WAIT_LOCK
      tbl[6]  = mk(1, 0, 20, 1, 0, 1, 2, 0, 2, 0, 0);  // 55: relock, err stays
      tbl[7]  = mk(0, 0, 4,  0, 0, 1, 2, 0, 3, 0, 0);  // 59: LOST again
      tbl[8]  = mk(0, 0, 1,  0, 0, 1, 2, 0, 0, 0, 0);  // 60
      tbl[9]  = mk(1, 0, 8,  0, 0, 1, 2, 0, 1, 0, 0);  // 68: 8-cycle glitch high
      tbl[10] = mk(0, 0, 3,  0, 0, 1, 2, 0, 1, 0, 0);  // 71
      tbl[11] = mk(0, 0, 1,  0, 0, 1, 2, 0, 0, 1, 7);  // 72: glitch exit, no relock
      tbl[12] = mk(1, 0, 19, 0, 0, 1, 2, 0, 1, 1, 7);  // 91
      tbl[13] = mk(1, 1, 1,  1, 0, 0, 0, 0, 2, 0, 7);  // 92: clr on LOCKED entry wins
      tbl[14] = mk(1, 0, 1,  1, 0, 0, 0, 0, 2, 0, 7);  // 93
      tbl[15] = mk(0, 0, 5,  0, 0, 1, 0, 0, 0, 0, 7);  // 98: lost, WAIT tmr=0
      tbl[16] = mk(0, 0, 99, 0, 0, 1, 0, 0, 0, 0, 7);  // 197
      tbl[17] = mk(0, 0, 1,  0, 1, 1, 0, 1, 4, 0, 7);  // 198: first pulse
      tbl[18] = mk(0, 0, 3,  0, 1, 1, 0, 1, 4, 0, 7);  // 201: last pulse cycle
      tbl[19] = mk(0, 0, 1,  0, 0, 1, 0, 1, 0, 0, 7);  // 202: pulse was 4 wide
      tbl[20] = mk(0, 0, 99, 0, 0, 1, 0, 1, 0, 0, 7);  // 301
      tbl[21] = mk(0, 0, 1,  0, 1, 1, 0, 2, 4, 0, 7);  // 302: second pulse

      rst_n = 1'b0;
      step(3);
      chk("reset_state", snap(), 64'd0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         pll_lock = tbl[i].lock;
         clr_err  = tbl[i].clr;
         sbq.push_back(tbl[i]);
         step(tbl[i].n);
         e = sbq.pop_front();
         chk($sformatf("vec%0d", i), snap(), pack_exp(e));
      end
      clr_err = 1'b0;

      // async reset in the 2nd pulse cycle, no clock edge in between
      step(1);
      chk("pulse_cycle2", 64'({pll_rst_req, state}), 64'({1'b1, 3'd4}));
      #2 rst_n = 1'b0;
      #1 chk("async_rst", snap(), 64'd0);
      #2 rst_n = 1'b1;

      // lock arriving during RST_REQ is ignored until the pulse ends
      step(99);
      chk("pre_timeout", 64'({pll_rst_req, state}), 64'd0);
      pll_lock = 1'b1;
      step(1);
      chk("rst_req_entry", 64'({pll_rst_req, state, timeout_cnt}), 64'({1'b1, 3'd4, 8'd1}));
      step(3);
      chk("rst_req_ignores_lk", 64'({pll_rst_req, state}), 64'({1'b1, 3'd4}));
      step(1);
      chk("rst_req_exit", 64'({pll_rst_req, state}), 64'd0);
      step(1);
      chk("debounce_after_pulse", 64'(state), 64'd1);

      // timeout counter saturates rather than wrapping
      pll_lock = 1'b0;
      step(27000);
      chk("timeout_sat", 64'(timeout_cnt), 64'd255);
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      chk("clr_counters", 64'({timeout_cnt, relock_cnt, err_sticky}), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
